// File: rtl/timebase_sampler_pkg.sv
// timebase_pkg: shared definitions for the timebase sampler slice.
//   BASE_W / BASE_MAX : width and largest value of the timebase index.
//   tb_state_t        : sampler state (idle / capturing a frame).
//   tb_period()       : sample period in clk50 cycles for a given index.
package timebase_pkg;

  localparam int BASE_W   = 3;
  localparam int BASE_MAX = 7;

  typedef enum logic {
    TB_IDLE,
    TB_CAPTURE
  } tb_state_t;

  // Each step up in the timebase index doubles the sample period.
  function automatic int unsigned tb_period(input logic [BASE_W-1:0] base,
                                            input int unsigned       div_base);
    return div_base << base;
  endfunction

endpackage

// File: rtl/timebase_sampler_if.sv
// timebase_sampler_if: bundles the selector-side inputs and the capture-side
// outputs of the timebase sampler.
//   base, base_chg, arm              : from the timebase selector / control
//   sample_en, wr_en, wr_addr        : ADC strobe and capture-RAM write port
//   cur_base, busy, frame_done       : status
// Modports: master drives the requests and observes status; slave is the
// sampler itself.
interface timebase_sampler_if #(
  parameter int ADDR_W = 9
);
  import timebase_pkg::*;

  logic [BASE_W-1:0] base;
  logic              base_chg;
  logic              arm;
  logic              sample_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BASE_W-1:0] cur_base;
  logic              busy;
  logic              frame_done;

  modport master (
    output base, base_chg, arm,
    input  sample_en, wr_en, wr_addr, cur_base, busy, frame_done
  );

  modport slave (
    input  base, base_chg, arm,
    output sample_en, wr_en, wr_addr, cur_base, busy, frame_done
  );

endinterface

// File: rtl/timebase_sampler_divider.sv
// tb_divider: free-running sample-period divider.
//   clk50  : system clock
//   rst    : synchronous active-high reset
//   clear  : forces the count back to 0 on the next edge
//   period : current sample period P (1 .. 2^DIV_W)
//   tick   : high while the count sits at P-1 (last cycle of a period)
// The counter wraps to 0 by itself after a tick.
module tb_divider #(
  parameter int DIV_W = 7
) (
  input  logic           clk50,
  input  logic           rst,
  input  logic           clear,
  input  logic [DIV_W:0] period,
  output logic           tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // The period needs one more bit than the count, so compare at period width.
  assign tick = ({1'b0, div_q} == (period - (DIV_W+1)'(1)));

  always_comb begin
    div_d = div_q;
    if (clear || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/timebase_sampler.sv
// timebase_sampler: generates the ADC sample strobe and capture-RAM write
// stream for one acquisition frame of 2^ADDR_W samples, one sample every
// DIV_BASE << cur_base cycles of clk50.
//   clk50 : system clock        rst : synchronous active-high reset
//   bus   : timebase_sampler_if.slave (base/base_chg/arm in,
//           sample_en/wr_en/wr_addr/cur_base/busy/frame_done out)
// Optional feature: define TIMEBASE_AUTO_REARM_EN to start the next frame
// immediately after each completed frame instead of returning to idle.
module timebase_sampler
  import timebase_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter int unsigned DIV_BASE = 1
) (
  input  logic               clk50,
  input  logic               rst,
  timebase_sampler_if.slave  bus
);

  // Count must reach DIV_BASE*128 - 1 (the period at the slowest timebase).
  localparam int DIV_W = $clog2(DIV_BASE * 128);

  tb_state_t         state_q,    state_d;
  logic [BASE_W-1:0] cur_base_q, cur_base_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic              frame_done_q, frame_done_d;

  logic [DIV_W:0]    period;
  logic              tick;
  logic              div_clear;
  logic              busy;
  logic              sample_en;

  assign period = (DIV_W+1)'(tb_period(cur_base_q, DIV_BASE));

  // Divider is held at 0 while idle, so an arm always starts from a fresh
  // period; a timebase change restarts the period as well.
  assign div_clear = (state_q == TB_IDLE) || bus.base_chg;

  tb_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk50  (clk50),
    .rst    (rst),
    .clear  (div_clear),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q      <= TB_IDLE;
      cur_base_q   <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_base_q   <= cur_base_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_base_d   = cur_base_q;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;
    case (state_q)
      TB_IDLE: begin
        if (bus.base_chg || bus.arm) begin
          cur_base_d = bus.base;
        end
        if (bus.arm) begin
          wr_addr_d = '0;
          state_d   = TB_CAPTURE;
        end
      end
      TB_CAPTURE: begin
        if (bus.base_chg) begin
          cur_base_d = bus.base;
          wr_addr_d  = '0;
        end else if (sample_en) begin
          if (wr_addr_q == '1) begin
            frame_done_d = 1'b1;
            wr_addr_d    = '0;
`ifdef TIMEBASE_AUTO_REARM_EN
            state_d      = TB_CAPTURE;
`else
            state_d      = TB_IDLE;
`endif
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = TB_IDLE;
    endcase
  end

  // A timebase change suppresses the strobe even when the period expires.
  always_comb begin
    busy      = (state_q == TB_CAPTURE);
    sample_en = busy && tick && !bus.base_chg;
  end

  assign bus.sample_en  = sample_en;
  assign bus.wr_en      = sample_en;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.cur_base   = cur_base_q;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_timebase_sampler.sv
// tb_timebase_sampler: self-checking bench for timebase_sampler with
// ADDR_W=4 (16-sample frames) and DIV_BASE=1. A frame-position model runs
// alongside the DUT, plus directed scenarios with literal expectations.
// Honours TIMEBASE_AUTO_REARM_EN when the design is built with it.
module tb_timebase_sampler;
  import timebase_pkg::*;

  localparam int          ADDR_W   = 4;
  localparam int unsigned DIV_BASE = 1;
  localparam int          FRAME    = 16;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   found;

  timebase_sampler_if #(.ADDR_W(ADDR_W)) bus ();

  timebase_sampler #(
    .ADDR_W   (ADDR_W),
    .DIV_BASE (DIV_BASE)
  ) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk50 = ~clk50;

  initial begin
    bus.base     = '0;
    bus.base_chg = 1'b0;
    bus.arm      = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge and hold for the whole cycle.
  task automatic applyStimulus(input logic r, input logic [2:0] b,
                               input logic chg, input logic a);
    @(posedge clk50);
    #1;
    rst          = r;
    bus.base     = b;
    bus.base_chg = chg;
    bus.arm      = a;
  endtask

  task automatic resetPulse();
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
  endtask

  // Frame-position model: m_t counts cycles since the current frame began;
  // a sample is due whenever (m_t+1) is a multiple of the period, and its
  // address is how many whole periods have elapsed minus one.
  bit m_valid  = 0;
  bit m_active = 0;
  bit m_done   = 0;
  int m_base   = 0;
  int m_t      = 0;

  always @(negedge clk50) begin
    int p;
    bit exp_se;
    int exp_addr;
    p        = int'(DIV_BASE) << m_base;
    exp_se   = m_active && !bus.base_chg && (((m_t + 1) % p) == 0);
    exp_addr = (m_t + 1) / p - 1;
    if (m_valid) begin
      checkOutput("busy", 32'(bus.busy), 32'(m_active));
      checkOutput("cur_base", 32'(bus.cur_base), 32'(m_base));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(m_done));
      checkOutput("sample_en", 32'(bus.sample_en), 32'(exp_se));
      checkOutput("wr_en", 32'(bus.wr_en), 32'(exp_se));
      if (exp_se) checkOutput("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
      if (!m_active) checkOutput("idle_wr_addr", 32'(bus.wr_addr), 32'd0);
    end
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_done   = 0;
      m_base   = 0;
      m_t      = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (bus.base_chg || bus.arm) m_base = int'(bus.base);
      if (bus.arm) begin
        m_active = 1;
        m_t      = 0;
      end
    end else begin
      m_done = 0;
      if (bus.base_chg) begin
        m_base = int'(bus.base);
        m_t    = 0;
      end else if (exp_se && exp_addr == FRAME - 1) begin
        m_done = 1;
        m_t    = 0;
`ifndef TIMEBASE_AUTO_REARM_EN
        m_active = 0;
`endif
      end else begin
        m_t++;
      end
    end
  end

  initial begin
    // Reset values
    resetPulse();
    resetPulse();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cur_base", 32'(bus.cur_base), 32'd0);
    checkOutput("rst_sample_en", 32'(bus.sample_en), 32'd0);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);

    // base=0: a write every cycle for 16 cycles, then frame_done
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 1; i <= FRAME; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk50);
      checkOutput("s1_sample_en", 32'(bus.sample_en), 32'd1);
      checkOutput("s1_wr_addr", 32'(bus.wr_addr), 32'(i - 1));
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("s1_frame_done", 32'(bus.frame_done), 32'd1);
`ifdef TIMEBASE_AUTO_REARM_EN
    checkOutput("s1_busy_rearm", 32'(bus.busy), 32'd1);
    checkOutput("s1_wrap_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("s1_wrap_sample", 32'(bus.sample_en), 32'd1);
`else
    checkOutput("s1_busy_drop", 32'(bus.busy), 32'd0);
    checkOutput("s1_no_sample", 32'(bus.sample_en), 32'd0);
`endif

    // base=3: first strobe 8 cycles after arm
    resetPulse();
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 3'd3, 1'b0, 1'b0);
      @(negedge clk50);
      checkOutput("s2_sample_en", 32'(bus.sample_en), 32'(i == 8));
    end
    checkOutput("s2_cur_base", 32'(bus.cur_base), 32'd3);
    checkOutput("s2_first_addr", 32'(bus.wr_addr), 32'd0);

    // Timebase change one cycle after the wr_addr=5 write
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(1'b0, 3'd3, 1'b0, 1'b0);
      @(negedge clk50);
      if (bus.sample_en && bus.wr_addr == 4'd5) found = 1;
    end
    checkOutput("s3_reached_addr5", 32'(found), 32'd1);
    applyStimulus(1'b0, 3'd2, 1'b1, 1'b0);
    @(negedge clk50);
    checkOutput("s3_chg_no_strobe", 32'(bus.sample_en), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
      @(negedge clk50);
      checkOutput("s3_new_period", 32'(bus.sample_en), 32'(i == 4));
    end
    checkOutput("s3_cur_base", 32'(bus.cur_base), 32'd2);
    checkOutput("s3_busy", 32'(bus.busy), 32'd1);
    checkOutput("s3_restart_addr", 32'(bus.wr_addr), 32'd0);

    // Timebase change exactly on a due sample suppresses it
    resetPulse();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    @(negedge clk50);
    checkOutput("s3b_suppress", 32'(bus.sample_en), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("s3b_resume", 32'(bus.sample_en), 32'd1);
    checkOutput("s3b_resume_addr", 32'(bus.wr_addr), 32'd0);

    // arm while capturing is ignored
    resetPulse();
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("s4_arm_ignored_se", 32'(bus.sample_en), 32'd1);
    checkOutput("s4_arm_ignored_addr", 32'(bus.wr_addr), 32'd2);
    checkOutput("s4_arm_ignored_base", 32'(bus.cur_base), 32'd1);

    // arm + base_chg together in idle: capture uses the new base (P=32)
    resetPulse();
    applyStimulus(1'b0, 3'd5, 1'b1, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b0, 3'd5, 1'b0, 1'b0);
      @(negedge clk50);
      checkOutput("s4_p32", 32'(bus.sample_en), 32'(i == 32));
    end
    checkOutput("s4_cur_base", 32'(bus.cur_base), 32'd5);

    // rst in mid-frame at wr_addr=7 (base=2, write 7 lands 32 cycles after arm)
    resetPulse();
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b1);
    for (int i = 1; i < 32; i++) applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("s5_addr7", 32'(bus.wr_addr), 32'd7);
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
    @(negedge clk50);
    checkOutput("s5_busy", 32'(bus.busy), 32'd0);
    checkOutput("s5_sample_en", 32'(bus.sample_en), 32'd0);
    checkOutput("s5_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("s5_cur_base", 32'(bus.cur_base), 32'd0);
    checkOutput("s5_frame_done", 32'(bus.frame_done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
      @(negedge clk50);
      checkOutput("s5_stays_idle", 32'(bus.busy), 32'd0);
    end

    // Randomized traffic, checked by the model every cycle
    resetPulse();
    for (int n = 0; n < 4000; n++) begin
      logic       r, chg, a;
      logic [2:0] b;
      r   = ($urandom_range(0, 299) == 0);
      chg = ($urandom_range(0, 59) == 0);
      a   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) b = 3'($urandom_range(0, 7));
      else                           b = 3'($urandom_range(0, 3));
      applyStimulus(r, b, chg, a);
    end

    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
